// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared widths, core-id sizing and op-kind constants for the memory port arbiter
package gpu_mem_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    function automatic int cid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after the pointer
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NCORES = 4,
    localparam int IW = cid_w(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NCORES-1:0] gnt,
    output logic [IW-1:0]     idx
);
    // scan from ptr, wrapping, and take the first asserted request
    always_comb begin
        int c;
        logic found;
        c = 0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < NCORES; k++) begin
            c = (int'(ptr) + k) % NCORES;
            if (!found && req[c]) begin
                found = 1'b1;
                idx = IW'(c);
            end
        end
        gnt = found ? (NCORES'(1) << idx) : '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: per-core read/write slots shared onto one synchronous RAM by round-robin
module mem_port_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCORES-1:0]    core_mem_read,
    input  logic [NCORES*AW-1:0] core_mem_addr,
    output logic [NCORES-1:0]    core_mem_ready,
    output logic [DW-1:0]        core_mem_data,
    input  logic [NCORES-1:0]    core_mem_write,
    input  logic [NCORES*AW-1:0] core_wr_addr,
    input  logic [NCORES*DW-1:0] core_wr_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata,
    output logic                 busy,
    output logic                 err
);
    localparam int IW = cid_w(NCORES);

    logic [NCORES-1:0] rd_v, wr_v, gnt, rd_clr, wr_clr, rd_keep, wr_keep, rd_n, wr_n;
    logic [AW-1:0]     rd_a [NCORES];
    logic [AW-1:0]     wr_a [NCORES];
    logic [DW-1:0]     wr_d [NCORES];
    logic [IW-1:0]     g, rr, inf_id;
    logic              any, op, rd_go, inf_v, busy_q, err_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;

    rr_arbiter #(.NCORES(NCORES)) u_arb (
        .req(rd_v | wr_v),
        .ptr(rr),
        .gnt(gnt),
        .idx(g)
    );

    // the write slot of the granted core goes first so same-core reads see the new data
    assign any     = |gnt;
    assign op      = wr_v[g] ? OP_WR : OP_RD;
    assign rd_go   = any && op == OP_RD;
    assign rd_clr  = rd_go ? gnt : '0;
    assign wr_clr  = (any && op == OP_WR) ? gnt : '0;
    assign rd_keep = rd_v & ~rd_clr;
    assign wr_keep = wr_v & ~wr_clr;
    assign rd_n    = rd_keep | core_mem_read;
    assign wr_n    = wr_keep | core_mem_write;

    assign ram_en    = any && !reset;
    assign ram_we    = ram_en && op == OP_WR;
    assign ram_addr  = any ? (op == OP_WR ? wr_a[g] : rd_a[g]) : addr_q;
    assign ram_wdata = (any && op == OP_WR) ? wr_d[g] : wdata_q;

    assign core_mem_ready = (inf_v && !reset) ? (NCORES'(1) << inf_id) : '0;
    assign core_mem_data  = ram_rdata;
    assign busy           = busy_q && !reset;
    assign err            = err_q && !reset;

    // slot payloads load only when the slot is free or being freed this edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORES; i++) begin
            if (core_mem_read[i] && !rd_keep[i]) rd_a[i] <= core_mem_addr[i*AW +: AW];
            if (core_mem_write[i] && !wr_keep[i]) begin
                wr_a[i] <= core_wr_addr[i*AW +: AW];
                wr_d[i] <= core_wr_data[i*DW +: DW];
            end
        end
    end

    // slot valids, pointer, in-flight read, held RAM drive, busy and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v    <= '0;
            wr_v    <= '0;
            rr      <= '0;
            inf_v   <= 1'b0;
            inf_id  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rd_v   <= rd_n;
            wr_v   <= wr_n;
            inf_v  <= rd_go;
            inf_id <= g;
            busy_q <= |rd_n || |wr_n || rd_go;
            err_q  <= err_q || |(core_mem_read & rd_keep) || |(core_mem_write & wr_keep);
            if (any) begin
                rr     <= (g == IW'(NCORES - 1)) ? '0 : g + 1'b1;
                addr_q <= ram_addr;
                if (op == OP_WR) wdata_q <= ram_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and hand-sequenced checks of the memory port arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  core_mem_read = '0;
    logic [63:0] core_mem_addr = '0;
    logic [3:0]  core_mem_ready;
    logic [15:0] core_mem_data;
    logic [3:0]  core_mem_write = '0;
    logic [63:0] core_wr_addr = '0;
    logic [63:0] core_wr_data = '0;
    logic        ram_en, ram_we, busy, err;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic [15:0] mem [256];

    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .core_mem_read(core_mem_read), .core_mem_addr(core_mem_addr),
        .core_mem_ready(core_mem_ready), .core_mem_data(core_mem_data),
        .core_mem_write(core_mem_write), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            else ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [15:0] abase;
        logic [15:0] wd;
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdat;
        logic [3:0]  rdy;
        logic [15:0] data;
        logic        bsy;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_mem_read = '0;
        core_mem_write = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", ram_en, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_ready", core_mem_ready, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int rdy0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        mem[8'h10] = 16'hBEEF;

        vecs[0]  = '{4'b1111, 4'b0000, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'b0000, 16'h0000, 1'b1};
        vecs[2]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0000, 4'b0001, 16'hA585, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0022, 16'h0000, 4'b0010, 16'hA584, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0023, 16'h0000, 4'b0100, 16'hA587, 1'b1};
        vecs[5]  = '{4'b0010, 4'b0000, 16'h000F, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b1000, 16'hA586, 1'b1};
        vecs[6]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 4'b0000, 16'h0000, 1'b1};
        vecs[7]  = '{4'b0100, 4'b0100, 16'h003E, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0010, 16'hBEEF, 1'b1};
        vecs[8]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1234, 4'b0000, 16'h0000, 1'b1};
        vecs[9]  = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 4'b0000, 16'h0000, 1'b1};
        vecs[10] = '{4'b1000, 4'b0000, 16'h0047, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0100, 16'h1234, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h004A, 16'h0000, 4'b0000, 16'h0000, 1'b1};
        vecs[12] = '{4'b1001, 4'b0000, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b1000, 16'hA5EF, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000, 4'b0000, 16'h0000, 1'b1};
        vecs[14] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0053, 16'h0000, 4'b0001, 16'hA5F5, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b1000, 16'hA5F6, 1'b1};
        vecs[16] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 1'b0};

        do_reset();

        for (int v = 0; v < 17; v++) begin
            core_mem_read = vecs[v].rd;
            core_mem_write = vecs[v].wr;
            for (int i = 0; i < 4; i++) begin
                core_mem_addr[i*16 +: 16] = vecs[v].abase + 16'(i);
                core_wr_addr[i*16 +: 16] = vecs[v].abase + 16'(i);
                core_wr_data[i*16 +: 16] = vecs[v].wd;
            end
            chk($sformatf("v%0d_en", v), ram_en, vecs[v].en);
            chk($sformatf("v%0d_ready", v), core_mem_ready, vecs[v].rdy);
            chk($sformatf("v%0d_busy", v), busy, vecs[v].bsy);
            chk($sformatf("v%0d_err", v), err, 1'b0);
            if (vecs[v].en) begin
                chk($sformatf("v%0d_we", v), ram_we, vecs[v].we);
                chk($sformatf("v%0d_addr", v), ram_addr, vecs[v].addr);
                if (vecs[v].we) chk($sformatf("v%0d_wdata", v), ram_wdata, vecs[v].wdat);
            end
            if (vecs[v].rdy != 4'b0) chk($sformatf("v%0d_data", v), core_mem_data, vecs[v].data);
            tick();
        end
        idle_inputs();

        // protocol error: core 0 re-pulses while its read waits behind cores 1..3
        core_mem_read = 4'b0001;
        core_mem_addr[15:0] = 16'h0001;
        tick();
        idle_inputs();
        chk("pe_first_grant", ram_addr, 16'h0001);
        tick();
        core_mem_read = 4'b1111;
        core_mem_addr = {16'h0063, 16'h0062, 16'h0061, 16'h0005};
        tick();
        chk("pe_err_before", err, 1'b0);
        chk("pe_grant_core1", ram_addr, 16'h0061);
        core_mem_read = 4'b0001;
        core_mem_addr[15:0] = 16'h0006;
        tick();
        idle_inputs();
        rdy0 = 0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("pe_err_k%0d", k), err, 1'b1);
            if (k == 2) begin
                chk("pe_core0_en", ram_en, 1'b1);
                chk("pe_core0_addr", ram_addr, 16'h0005);
            end
            if (core_mem_ready[0]) begin
                rdy0++;
                chk("pe_core0_data", core_mem_data, 16'hA5A0);
            end
            tick();
        end
        chk("pe_ready_count", rdy0, 1);

        // reset in the cycle after a read grant suppresses the ready
        do_reset();
        core_mem_read = 4'b0010;
        core_mem_addr[31:16] = 16'h0010;
        tick();
        idle_inputs();
        chk("rm_grant_en", ram_en, 1'b1);
        chk("rm_grant_addr", ram_addr, 16'h0010);
        tick();
        reset = 1'b1;
        #1;
        chk("rm_ready_in_reset", core_mem_ready, 4'b0);
        chk("rm_en_in_reset", ram_en, 1'b0);
        chk("rm_busy_in_reset", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rm_ready_after", core_mem_ready, 4'b0);
        chk("rm_en_after", ram_en, 1'b0);
        chk("rm_busy_after", busy, 1'b0);
        chk("rm_err_after", err, 1'b0);
        core_mem_read = 4'b0100;
        core_mem_addr[47:32] = 16'h0011;
        tick();
        idle_inputs();
        chk("rm_fresh_en", ram_en, 1'b1);
        chk("rm_fresh_addr", ram_addr, 16'h0011);
        chk("rm_fresh_ready_early", core_mem_ready, 4'b0);
        tick();
        chk("rm_fresh_ready", core_mem_ready, 4'b0100);
        chk("rm_fresh_data", core_mem_data, 16'hA5B4);
        tick();
        chk("rm_ready_clear", core_mem_ready, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
